vram_line_fetch: RTL and testbench
==================================

VRAM_LINE_FETCH -- requirements
Module: vram_line_fetch

Interface
REQ-001 Parameter WORDS_LOG2, default 6, gives log2 of 64-bit words per line: 64 words, 512 bytes.
REQ-002 Port CLK, input, 1, sole clock; every register updates on the rising edge.
REQ-003 Port RST, input, 1, reset; synchronous and active-high.
REQ-004 Port XFER_REQ, input, 1, single-cycle transfer start request.
REQ-005 Port XFER_ADDR, input, [15:3], VRAM word address of the first word of the line.
REQ-006 Port XFER_BANK, input, 1, line-buffer bank that the transfer writes.
REQ-007 Port XFER_BUSY, output, 1, high while a transfer is in progress.
REQ-008 Port XFER_DONE, output, 1, one-cycle pulse when a transfer completes.
REQ-009 Port SADDR, output, [15:3], VRAM serial-port word address.
REQ-010 Port SQ, input, [63:0], VRAM serial-port read data, valid the cycle after SADDR is sampled.
REQ-011 Port LB_WADDR, output, [WORDS_LOG2+3:3], line-buffer write word address {bank, word}.
REQ-012 Port LB_DATA, output, [63:0], line-buffer write data.
REQ-013 Port LB_WREN, output, [7:0], line-buffer byte write enables.
REQ-014 Port LB_RADDR, output, [WORDS_LOG2+3:3], line-buffer read word address {bank, word}.
REQ-015 Port LB_Q, input, [63:0], line-buffer read data, combinational from LB_RADDR.
REQ-016 Port PIX_START, input, 1, loads the pixel pointer and read bank.
REQ-017 Port PIX_START_X, input, [WORDS_LOG2+2:0], starting byte index within the line.
REQ-018 Port PIX_BANK, input, 1, bank to read, captured on PIX_START.
REQ-019 Port PIX_CE, input, 1, pixel clock enable.
REQ-020 Port PIX_OUT, output, [7:0], registered pixel byte.

Function
REQ-021 The fetch FSM SHALL have states IDLE, FETCH and FLUSH.
REQ-022 In IDLE, XFER_REQ=1 SHALL latch XFER_ADDR into the address counter, XFER_BANK into the write bank, clear the word counter, and move to FETCH.
REQ-023 In FETCH, SADDR SHALL equal the address counter each cycle; the address counter and word counter SHALL each increment by 1.
REQ-024 The address counter SHALL be 13 bits and wrap from 0x1FFF to 0x0000.
REQ-025 When the word counter reaches 2^WORDS_LOG2-1 in FETCH, the FSM SHALL move to FLUSH the next cycle.
REQ-026 The FSM SHALL stay in FLUSH for exactly one cycle, then return to IDLE with XFER_DONE=1 for that one cycle.
REQ-027 The write pipeline SHALL be one stage: a word issued on SADDR in cycle t SHALL be presented in cycle t+1.
- In cycle t+1: LB_DATA=SQ combinationally, LB_WADDR={write bank, word index of t}, LB_WREN=8'hFF.
- In every other cycle: LB_WREN=8'h00.
REQ-028 XFER_BUSY SHALL be 1 in FETCH and FLUSH and 0 in IDLE.
REQ-029 XFER_REQ while busy SHALL be ignored, with no queuing and no effect on the transfer in progress.
REQ-030 A transfer SHALL take 2^WORDS_LOG2+1 cycles from the cycle after XFER_REQ to XFER_DONE.
REQ-031 When idle, SADDR SHALL hold its last value and SHALL NOT affect the data path.
REQ-032 The pixel pointer X SHALL be a register of WORDS_LOG2+3 bits.
REQ-033 LB_RADDR SHALL equal {read bank, X[WORDS_LOG2+2:3]}.
REQ-034 On PIX_START: X <= PIX_START_X, read bank <= PIX_BANK, and PIX_OUT SHALL be unchanged.
REQ-035 On PIX_CE without PIX_START: PIX_OUT <= LB_Q byte X[2:0] (byte 0 = bits 7:0), then X <= X+1.
REQ-036 X SHALL wrap modulo 2^(WORDS_LOG2+3) within the same bank.
REQ-037 PIX_START and PIX_CE in the same cycle SHALL be treated as PIX_START only.
REQ-038 The pixel path SHALL run independently of the fetch FSM.
REQ-039 Reading the bank currently being written SHALL be permitted; the data returned is whatever the line buffer holds.

Reset
REQ-040 RST SHALL set: FSM=IDLE, XFER_BUSY=0, XFER_DONE=0, LB_WREN=0, SADDR=0, X=0, read bank=0, write bank=0, PIX_OUT=0.
REQ-041 RST during FETCH or FLUSH SHALL abort the transfer.
- No further LB writes occur, including the pending pipeline write.
- XFER_DONE is not asserted.
REQ-042 RST SHALL take priority over every other input in the same cycle.

Verification
REQ-043 Transfer: XFER_REQ with ADDR=0x0100, BANK=1, SQ model = address.
- 64 writes with LB_WADDR 0x40..0x7F and LB_DATA 0x100..0x13F.
- XFER_DONE exactly 65 cycles after the request cycle.
REQ-044 Wrap: XFER_ADDR=0x1FF0 -> SADDR sequence 0x1FF0..0x1FFF then 0x0000..0x002F.
REQ-045 Busy: second XFER_REQ on cycle 10 of a transfer -> write sequence unchanged, one XFER_DONE only.
REQ-046 Pixels: LB bank 0 word 0 = 0x0706050403020100, word 1 = 0x0F0E0D0C0B0A0908; PIX_START X=6 then 4 PIX_CE -> PIX_OUT 06,07,08,09.
- PIX_START with PIX_CE in the same cycle -> PIX_OUT held.
REQ-047 Reset abort: RST asserted at FETCH word 20 -> next cycle BUSY=0, LB_WREN=0, no DONE; a new XFER_REQ then completes normally.

Source files
------------

// File: rtl/vram_line_fetch_if.sv
// vram_line_fetch_if: bundles the transfer, VRAM serial-port, line-buffer and pixel signals; slave = fetch block, master = host
interface vram_line_fetch_if #(parameter int WORDS_LOG2 = 6);
  logic                    xfer_req;
  logic [15:3]             xfer_addr;
  logic                    xfer_bank;
  logic                    xfer_busy;
  logic                    xfer_done;
  logic [15:3]             saddr;
  logic [63:0]             sq;
  logic [WORDS_LOG2+3:3]   lb_waddr;
  logic [63:0]             lb_data;
  logic [7:0]              lb_wren;
  logic [WORDS_LOG2+3:3]   lb_raddr;
  logic [63:0]             lb_q;
  logic                    pix_start;
  logic [WORDS_LOG2+2:0]   pix_start_x;
  logic                    pix_bank;
  logic                    pix_ce;
  logic [7:0]              pix_out;
  modport slave (
    input  xfer_req, xfer_addr, xfer_bank, sq, lb_q, pix_start, pix_start_x, pix_bank, pix_ce,
    output xfer_busy, xfer_done, saddr, lb_waddr, lb_data, lb_wren, lb_raddr, pix_out
  );
  modport master (
    output xfer_req, xfer_addr, xfer_bank, sq, lb_q, pix_start, pix_start_x, pix_bank, pix_ce,
    input  xfer_busy, xfer_done, saddr, lb_waddr, lb_data, lb_wren, lb_raddr, pix_out
  );
endinterface

// File: rtl/vram_line_fetch.sv
// vram_line_fetch: copies one VRAM line into a line-buffer bank (xfer_*/saddr/sq -> lb_w*) and streams pixel bytes out of a bank (pix_*/lb_raddr/lb_q); clk, sync active-high rst
module vram_line_fetch #(
  parameter int WORDS_LOG2 = 6
) (
  input logic              clk,
  input logic              rst,
  vram_line_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  localparam logic [WORDS_LOG2-1:0] LAST = '1;
  state_t                state;
  logic [12:0]           addr;
  logic                  wbank;
  logic [WORDS_LOG2-1:0] wcnt;
  logic                  wr_pend;
  logic [WORDS_LOG2-1:0] wr_word;
  logic                  busy;
  logic                  done;
  logic [WORDS_LOG2+2:0] x;
  logic                  rbank;
  logic [7:0]            pix;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      wbank   <= 1'b0;
      wcnt    <= '0;
      wr_pend <= 1'b0;
      wr_word <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          wr_pend <= 1'b0;
          if (bus.xfer_req) begin
            addr  <= bus.xfer_addr;
            wbank <= bus.xfer_bank;
            wcnt  <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          wr_pend <= 1'b1;
          wr_word <= wcnt;
          wcnt    <= wcnt + 1'b1;
          addr    <= (wcnt == LAST) ? addr : addr + 13'd1;
          if (wcnt == LAST) begin
            state <= FLUSH;
            done  <= 1'b1;
          end
        end
        FLUSH: begin
          wr_pend <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      rbank <= 1'b0;
      pix   <= '0;
    end else if (bus.pix_start) begin
      x     <= bus.pix_start_x;
      rbank <= bus.pix_bank;
    end else if (bus.pix_ce) begin
      pix <= bus.lb_q[{x[2:0], 3'b000} +: 8];
      x   <= x + 1'b1;
    end
  end
  assign bus.xfer_busy = busy;
  assign bus.xfer_done = done;
  assign bus.saddr     = addr;
  assign bus.lb_waddr  = {wbank, wr_word};
  assign bus.lb_data   = bus.sq;
  assign bus.lb_wren   = (wr_pend && !rst) ? 8'hFF : 8'h00;
  assign bus.lb_raddr  = {rbank, x[WORDS_LOG2+2:3]};
  assign bus.pix_out   = pix;
endmodule

// File: tb/tb_vram_line_fetch.sv
// tb_vram_line_fetch: directed scoreboard bench for vram_line_fetch with VRAM and line-buffer models
module tb_vram_line_fetch;
  localparam int W = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [63:0] vram [0:8191];
  logic [63:0] mem [0:127];
  logic [70:0] sb [$];
  always #5 clk = ~clk;
  vram_line_fetch_if #(.WORDS_LOG2(W)) bus ();
  vram_line_fetch #(.WORDS_LOG2(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) begin
    bus.sq <= vram[bus.saddr];
    if (bus.lb_wren == 8'hFF) mem[bus.lb_waddr] <= bus.lb_data;
  end
  assign bus.lb_q = mem[bus.lb_raddr];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [70:0] e;
    if (mon_en && bus.lb_wren !== 8'h00) begin
      if (sb.size() == 0) chk("spurious_write", 64'(bus.lb_wren), 64'd0);
      else begin
        e = sb.pop_front();
        chk("wr_wren", 64'(bus.lb_wren), 64'hFF);
        chk("wr_addr", 64'(bus.lb_waddr), 64'(e[70:64]));
        chk("wr_data", bus.lb_data, e[63:0]);
      end
    end
  end
  task automatic push_exp(input logic [12:0] a, input logic b, input int n);
    logic [12:0] aa;
    logic [5:0] w;
    for (int i = 0; i < n; i++) begin
      aa = a + 13'(i);
      w = 6'(i);
      sb.push_back({b, w, vram[aa]});
    end
  endtask
  task automatic xfer(input logic [12:0] a, input logic b, input int inj);
    int lat;
    logic [12:0] ea;
    lat = 0;
    @(negedge clk);
    bus.xfer_req = 1'b1;
    bus.xfer_addr = a;
    bus.xfer_bank = b;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) bus.xfer_req = 1'b0;
      if (inj != 0 && k == inj) begin
        bus.xfer_req = 1'b1;
        bus.xfer_addr = a ^ 13'h00AA;
        bus.xfer_bank = ~b;
      end
      if (inj != 0 && k == inj + 1) bus.xfer_req = 1'b0;
      if (k <= 64) begin
        ea = a + 13'(k - 1);
        chk("saddr", 64'(bus.saddr), 64'(ea));
      end
      if (bus.xfer_done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", 64'(lat), 64'd65);
    chk("busy_in_flush", 64'(bus.xfer_busy), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("done_single", 64'(bus.xfer_done), 64'd0);
      chk("busy_idle", 64'(bus.xfer_busy), 64'd0);
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    int nd;
    for (int i = 0; i < 8192; i++) vram[i] = 64'(i);
    vram[13'h0300] = 64'h0706050403020100;
    vram[13'h0301] = 64'h0F0E0D0C0B0A0908;
    vram[13'h033F] = 64'hA7A6A5A4A3A2A1A0;
    bus.xfer_req = 1'b0;
    bus.xfer_addr = '0;
    bus.xfer_bank = 1'b0;
    bus.pix_start = 1'b0;
    bus.pix_start_x = '0;
    bus.pix_bank = 1'b0;
    bus.pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.xfer_busy), 64'd0);
    chk("rst_done", 64'(bus.xfer_done), 64'd0);
    chk("rst_wren", 64'(bus.lb_wren), 64'd0);
    chk("rst_saddr", 64'(bus.saddr), 64'd0);
    chk("rst_pix_out", 64'(bus.pix_out), 64'd0);
    chk("rst_raddr", 64'(bus.lb_raddr), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    push_exp(13'h0100, 1'b1, 64);
    xfer(13'h0100, 1'b1, 0);
    push_exp(13'h1FF0, 1'b0, 64);
    xfer(13'h1FF0, 1'b0, 0);
    chk("saddr_hold", 64'(bus.saddr), 64'h002F);
    push_exp(13'h0400, 1'b1, 64);
    xfer(13'h0400, 1'b1, 10);
    push_exp(13'h0200, 1'b0, 20);
    @(negedge clk);
    bus.xfer_req = 1'b1;
    bus.xfer_addr = 13'h0200;
    bus.xfer_bank = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) bus.xfer_req = 1'b0;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(bus.xfer_busy), 64'd0);
    chk("abort_wren", 64'(bus.lb_wren), 64'd0);
    chk("abort_done", 64'(bus.xfer_done), 64'd0);
    rst = 1'b0;
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.xfer_done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    chk("abort_sb_drain", 64'(sb.size()), 64'd0);
    push_exp(13'h0200, 1'b0, 64);
    xfer(13'h0200, 1'b0, 0);
    push_exp(13'h0300, 1'b0, 64);
    xfer(13'h0300, 1'b0, 0);
    @(negedge clk);
    bus.pix_start = 1'b1;
    bus.pix_start_x = 9'd6;
    bus.pix_bank = 1'b0;
    @(negedge clk);
    bus.pix_start = 1'b0;
    chk("pix_start_hold", 64'(bus.pix_out), 64'd0);
    chk("pix_raddr", 64'(bus.lb_raddr), 64'd0);
    bus.pix_ce = 1'b1;
    @(negedge clk);
    chk("pix_06", 64'(bus.pix_out), 64'h06);
    @(negedge clk);
    chk("pix_07", 64'(bus.pix_out), 64'h07);
    @(negedge clk);
    chk("pix_08", 64'(bus.pix_out), 64'h08);
    @(negedge clk);
    chk("pix_09", 64'(bus.pix_out), 64'h09);
    bus.pix_start = 1'b1;
    bus.pix_start_x = 9'h1FF;
    @(negedge clk);
    bus.pix_start = 1'b0;
    chk("pix_start_ce_hold", 64'(bus.pix_out), 64'h09);
    chk("pix_raddr_last", 64'(bus.lb_raddr), 64'h3F);
    @(negedge clk);
    chk("pix_last_byte", 64'(bus.pix_out), 64'hA7);
    chk("pix_wrap_raddr", 64'(bus.lb_raddr), 64'h00);
    @(negedge clk);
    chk("pix_wrap_byte", 64'(bus.pix_out), 64'h00);
    bus.pix_ce = 1'b0;
    @(negedge clk);
    chk("pix_idle_hold", 64'(bus.pix_out), 64'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
